// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg: N:1 operand selector feeding a PIPE_DEPTH-stage register
// pipeline with valid tracking, stall (hold) and flush (bubble insertion).
// Out-of-range select codes yield zero data.
// Optional feature macro: PIPE_MUX_SEL_CHECK_EN adds a sticky sel_err output
// flagging any advancing valid entry whose select code is out of range.
module pipe_mux_reg #(
  parameter int WIDTH      = 16,
  parameter int NUM_IN     = 8,
  parameter int SEL_W      = 3,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        ctrl_sig,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        op,
  output logic                    op_valid
`ifdef PIPE_MUX_SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q  [PIPE_DEPTH];
  logic             valid_q [PIPE_DEPTH];
  logic [WIDTH-1:0] data_d  [PIPE_DEPTH];
  logic             valid_d [PIPE_DEPTH];
  logic             advance;

  assign advance = !flush && !stall;

  // Select the addressed input; codes with no matching input fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (ctrl_sig == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 0 takes the selected operand, zeroed for bubbles so idle slots carry no stale data.
  assign data_d[0]  = in_valid ? sel_data : '0;
  assign valid_d[0] = in_valid;

  // Later stages take the contents of the stage before them.
  genvar gi;
  generate
    for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_chain
      assign data_d[gi]  = data_q[gi-1];
      assign valid_d[gi] = valid_q[gi-1];
    end
  endgenerate

  // Pipeline registers: flush clears everything, stall holds, otherwise shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        data_q[i]  <= data_d[i];
        valid_q[i] <= valid_d[i];
      end
    end
  end

  assign op       = data_q[PIPE_DEPTH-1];
  assign op_valid = valid_q[PIPE_DEPTH-1];

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic sel_in_range;
  logic sel_err_q;

  assign sel_in_range = (32'(ctrl_sig) < NUM_IN);

  // Sticky error: only reset clears it, so a flush cannot hide a bad select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (advance && in_valid && !sel_in_range) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule
